// File: rtl/pmp_pkg.sv
// Shared definitions for the sequential PMP checker.
// Holds the cfg A-field encodings, access-type codes, route-vector bit positions,
// cfg-byte bit positions, the checker FSM state type and a route-vector helper.
// The optional NAPOT decode is controlled by the PMP_NAPOT_EN macro. It is used in
// pmp_entry_match.sv and does not affect this package.
package pmp_pkg;

    // cfg A field encodings
    localparam logic [1:0] A_OFF   = 2'd0;
    localparam logic [1:0] A_TOR   = 2'd1;
    localparam logic [1:0] A_NA4   = 2'd2;
    localparam logic [1:0] A_NAPOT = 2'd3;

    // Access type codes
    localparam logic [1:0] ACC_R    = 2'd0;
    localparam logic [1:0] ACC_W    = 2'd1;
    localparam logic [1:0] ACC_X    = 2'd2;
    localparam logic [1:0] ACC_RSVD = 2'd3;

    // Route vector bit positions
    localparam int unsigned ROUTE_GRANT = 0;
    localparam int unsigned ROUTE_FAULT = 1;

    // cfg byte layout: {L, 00, A[1:0], X, W, R}
    localparam int unsigned CFG_L    = 7;
    localparam int unsigned CFG_A_HI = 4;
    localparam int unsigned CFG_A_LO = 3;
    localparam int unsigned CFG_X    = 2;
    localparam int unsigned CFG_W    = 1;
    localparam int unsigned CFG_R    = 0;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StResp
    } state_e;

    // One-hot route vector for a grant/fault decision
    function automatic logic [1:0] route_vec(input logic grant);
        logic [1:0] v;
        v = '0;
        if (grant) v[ROUTE_GRANT] = 1'b1;
        else       v[ROUTE_FAULT] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational address match and permission check for a single PMP entry.
// Ports:
//   cfg       - entry cfg byte {L,00,A,X,W,R}
//   addr      - entry pmpaddr (paddr[PA_W-1:2] granularity)
//   prev_addr - pmpaddr of the entry below (0 for entry 0), TOR lower bound
//   paddr     - access physical address
//   acc       - access type (R/W/X/reserved)
//   priv_m    - access is M-mode
//   match     - address falls in this entry's region
//   allow     - access is permitted if this entry is the first match
// Macro PMP_NAPOT_EN: when defined A=NAPOT is decoded, otherwise it never matches.
module pmp_entry_match
    import pmp_pkg::*;
#(
    parameter int unsigned PA_W = 34
) (
    input  logic [7:0]      cfg,
    input  logic [PA_W-3:0] addr,
    input  logic [PA_W-3:0] prev_addr,
    input  logic [PA_W-1:0] paddr,
    input  logic [1:0]      acc,
    input  logic            priv_m,
    output logic            match,
    output logic            allow
);

    logic [PA_W-3:0] word;
    logic            unused_paddr_lo;
    logic            perm;

    assign word            = paddr[PA_W-1:2];
    assign unused_paddr_lo = ^paddr[1:0];

`ifdef PMP_NAPOT_EN
    // addr ^ (addr + 1) sets bits [t:0] where t is the trailing-ones count;
    // those bits are don't-care in the comparison. All-ones addr masks everything.
    logic [PA_W-3:0] napot_ign;
    logic            napot_hit;
    assign napot_ign = addr ^ (addr + {{(PA_W-3){1'b0}}, 1'b1});
    assign napot_hit = ((word ^ addr) & ~napot_ign) == '0;
`endif

    always_comb begin
        match = 1'b0;
        unique case (cfg[CFG_A_HI:CFG_A_LO])
            A_OFF:   match = 1'b0;
            // An empty range (prev_addr >= addr) cannot satisfy both bounds
            A_TOR:   match = (word >= prev_addr) && (word < addr);
            A_NA4:   match = (word == addr);
`ifdef PMP_NAPOT_EN
            A_NAPOT: match = napot_hit;
`else
            A_NAPOT: match = 1'b0;
`endif
            default: match = 1'b0;
        endcase
    end

    always_comb begin
        perm = 1'b0;
        unique case (acc)
            ACC_R:   perm = cfg[CFG_R];
            ACC_W:   perm = cfg[CFG_W];
            ACC_X:   perm = cfg[CFG_X];
            default: perm = 1'b0;
        endcase
    end

    // Unlocked entries do not constrain M-mode; reserved access never passes
    assign allow = (acc != ACC_RSVD) && ((priv_m && !cfg[CFG_L]) || perm);

endmodule

// File: rtl/pmp_check_seq.sv
// Sequential PMP checker: accepts one access at a time, scans the PMP entries one
// per cycle (first match wins) and returns a registered one-hot route {fault, grant}.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   i_req_valid/o_req_ready  - request handshake (ready only in idle)
//   i_paddr, i_acc, i_priv_m - access address, type, M-mode flag
//   o_res_valid/i_res_ready  - result handshake
//   o_route_2                - one-hot route [0] grant, [1] fault (00 when not valid)
//   o_hit_idx                - matching entry index, 0 when nothing matched
//   i_cfg_we, i_addr_we      - cfg byte / pmpaddr write strobes
//   i_wr_idx, i_wr_data      - write target entry and data
//   o_cfg_busy               - high outside idle; writes are dropped while high
// Macro PMP_NAPOT_EN: enables NAPOT decode in pmp_entry_match.
module pmp_check_seq
    import pmp_pkg::*;
#(
    parameter int unsigned PA_W  = 34,
    parameter int unsigned N_ENT = 8,
    parameter int unsigned IDX_W = $clog2(N_ENT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [PA_W-1:0]  i_paddr,
    input  logic [1:0]       i_acc,
    input  logic             i_priv_m,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [1:0]       o_route_2,
    output logic [IDX_W-1:0] o_hit_idx,
    input  logic             i_cfg_we,
    input  logic             i_addr_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [PA_W-3:0]  i_wr_data,
    output logic             o_cfg_busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENT - 1);

    state_e           state_q, state_d;
    logic [7:0]       cfg_q  [N_ENT];
    logic [PA_W-3:0]  addr_q [N_ENT];
    logic [PA_W-1:0]  paddr_q;
    logic [1:0]       acc_q;
    logic             priv_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] hit_q, hit_d;
    logic [1:0]       route_q, route_d;
    logic             accept;

    logic             idle;
    logic [IDX_W-1:0] above_idx;
    logic             above_tor_locked;
    logic             cfg_wr_en;
    logic             addr_wr_en;

    assign idle      = (state_q == StIdle);
    assign above_idx = i_wr_idx + 1'b1;

    // A locked TOR entry also freezes the pmpaddr below it (its lower bound)
    always_comb begin
        above_tor_locked = 1'b0;
        if (i_wr_idx != LAST_IDX) begin
            above_tor_locked = cfg_q[above_idx][CFG_L] &&
                               (cfg_q[above_idx][CFG_A_HI:CFG_A_LO] == A_TOR);
        end
    end

    assign cfg_wr_en  = i_cfg_we && idle && !cfg_q[i_wr_idx][CFG_L];
    assign addr_wr_en = i_addr_we && idle && !cfg_q[i_wr_idx][CFG_L] && !above_tor_locked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_ENT); i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            if (cfg_wr_en)  cfg_q[i_wr_idx]  <= i_wr_data[7:0];
            if (addr_wr_en) addr_q[i_wr_idx] <= i_wr_data;
        end
    end

    // Entry under evaluation this cycle
    logic [7:0]      cur_cfg;
    logic [PA_W-3:0] cur_addr;
    logic [PA_W-3:0] prev_addr;
    logic            ent_match;
    logic            ent_allow;

    assign cur_cfg   = cfg_q[idx_q];
    assign cur_addr  = addr_q[idx_q];
    assign prev_addr = (idx_q == '0) ? '0 : addr_q[idx_q - 1'b1];

    pmp_entry_match #(
        .PA_W (PA_W)
    ) u_entry_match (
        .cfg       (cur_cfg),
        .addr      (cur_addr),
        .prev_addr (prev_addr),
        .paddr     (paddr_q),
        .acc       (acc_q),
        .priv_m    (priv_q),
        .match     (ent_match),
        .allow     (ent_allow)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        route_d = route_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_req_valid) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (ent_match) begin
                    route_d = route_vec(ent_allow);
                    hit_d   = idx_q;
                    state_d = StResp;
                end else if (idx_q == LAST_IDX) begin
                    // No entry matched: only M-mode passes; reserved access still faults
                    route_d = route_vec(priv_q && (acc_q != ACC_RSVD));
                    hit_d   = '0;
                    state_d = StResp;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StResp: begin
                if (i_res_ready) begin
                    route_d = '0;
                    hit_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                route_d = '0;
                hit_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            hit_q   <= '0;
            route_q <= '0;
            paddr_q <= '0;
            acc_q   <= '0;
            priv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            route_q <= route_d;
            if (accept) begin
                paddr_q <= i_paddr;
                acc_q   <= i_acc;
                priv_q  <= i_priv_m;
            end
        end
    end

    assign o_req_ready = idle;
    assign o_cfg_busy  = !idle;
    assign o_res_valid = (state_q == StResp);
    assign o_route_2   = route_q;
    assign o_hit_idx   = hit_q;

endmodule

// File: tb/tb_pmp_check_seq.sv
// Self-checking bench for pmp_check_seq: directed vector tables, hand-written
// multi-cycle sequences (stall, reset mid-scan, write+accept, lock rules) and a
// randomized run compared against a behavioural model of the PMP rules.
module tb_pmp_check_seq;

    localparam int PA_W  = 34;
    localparam int N_ENT = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_req_valid;
    logic             o_req_ready;
    logic [PA_W-1:0]  i_paddr;
    logic [1:0]       i_acc;
    logic             i_priv_m;
    logic             o_res_valid;
    logic             i_res_ready;
    logic [1:0]       o_route_2;
    logic [IDX_W-1:0] o_hit_idx;
    logic             i_cfg_we;
    logic             i_addr_we;
    logic [IDX_W-1:0] i_wr_idx;
    logic [PA_W-3:0]  i_wr_data;
    logic             o_cfg_busy;

    pmp_check_seq #(
        .PA_W  (PA_W),
        .N_ENT (N_ENT),
        .IDX_W (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_paddr     (i_paddr),
        .i_acc       (i_acc),
        .i_priv_m    (i_priv_m),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_route_2   (o_route_2),
        .o_hit_idx   (o_hit_idx),
        .i_cfg_we    (i_cfg_we),
        .i_addr_we   (i_addr_we),
        .i_wr_idx    (i_wr_idx),
        .i_wr_data   (i_wr_data),
        .o_cfg_busy  (o_cfg_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [7:0]  m_cfg  [N_ENT];
    logic [31:0] m_addr [N_ENT];

    typedef struct {
        logic [33:0] pa;
        logic [1:0]  acc;
        bit          priv;
        logic [1:0]  route;
        int          hit;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < N_ENT; i++) begin
            m_cfg[i]  = '0;
            m_addr[i] = '0;
        end
    endfunction

    function automatic void m_write(input bit cwe, input bit awe, input int idx,
                                    input logic [31:0] d);
        bit locked    = m_cfg[idx][7];
        bit tor_above = 1'b0;
        if (idx < N_ENT - 1) tor_above = m_cfg[idx+1][7] && (m_cfg[idx+1][4:3] == 2'd1);
        if (cwe && !locked)               m_cfg[idx]  = d[7:0];
        if (awe && !locked && !tor_above) m_addr[idx] = d;
    endfunction

    function automatic void m_eval(input logic [33:0] pa, input logic [1:0] acc, input bit priv,
                                   output logic [1:0] route, output int hit, output int lat);
        logic [31:0] w = pa[33:2];
        for (int k = 0; k < N_ENT; k++) begin
            logic [31:0] lo = (k == 0) ? 32'd0 : m_addr[k-1];
            logic [31:0] hi = m_addr[k];
            bit m = 1'b0;
            case (m_cfg[k][4:3])
                2'd1: m = (w >= lo) && (w < hi);
                2'd2: m = (w == hi);
`ifdef PMP_NAPOT_EN
                2'd3: begin
                    int t = 0;
                    while (t < 32 && hi[t]) t++;
                    if (t == 32) m = 1'b1;
                    else m = ((w >> (t + 1)) == (hi >> (t + 1)));
                end
`endif
                default: m = 1'b0;
            endcase
            if (m) begin
                bit ok = (acc != 2'd3) && ((priv && !m_cfg[k][7]) || m_cfg[k][acc]);
                route = ok ? 2'b01 : 2'b10;
                hit   = k;
                lat   = k + 1;
                return;
            end
        end
        route = (priv && acc != 2'd3) ? 2'b01 : 2'b10;
        hit   = 0;
        lat   = N_ENT;
    endfunction

    task automatic idle_write(input bit cwe, input bit awe, input int idx, input logic [31:0] d);
        i_cfg_we  = cwe;
        i_addr_we = awe;
        i_wr_idx  = IDX_W'(idx);
        i_wr_data = d;
        @(posedge clk); #1;
        i_cfg_we  = 1'b0;
        i_addr_we = 1'b0;
        m_write(cwe, awe, idx, d);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
    endtask

    // Issue one request (optionally with a simultaneous write), wait for the result,
    // complete the handshake and return the observed route, index and latency.
    task automatic do_req(input logic [33:0] pa, input logic [1:0] acc, input bit priv,
                          input bit cwe, input bit awe, input int widx, input logic [31:0] wd,
                          output logic [1:0] route, output int hit, output int lat);
        i_req_valid = 1'b1;
        i_paddr     = pa;
        i_acc       = acc;
        i_priv_m    = priv;
        i_cfg_we    = cwe;
        i_addr_we   = awe;
        i_wr_idx    = IDX_W'(widx);
        i_wr_data   = wd;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        i_cfg_we    = 1'b0;
        i_addr_we   = 1'b0;
        m_write(cwe, awe, widx, wd);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (o_res_valid) break;
        end
        if (!o_res_valid) check("res_timeout", 64'(o_res_valid), 64'd1);
        route = o_route_2;
        hit   = int'(o_hit_idx);
        i_res_ready = 1'b1;
        @(posedge clk); #1;
        i_res_ready = 1'b0;
        check("post_ready", 64'(o_req_ready), 64'd1);
        check("post_valid", 64'(o_res_valid), 64'd0);
        check("post_route", 64'(o_route_2), 64'd0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic [1:0] r;
        int h, l;
        do_req(v.pa, v.acc, v.priv, 1'b0, 1'b0, 0, 32'd0, r, h, l);
        check({tag, "_route"}, 64'(r), 64'(v.route));
        check({tag, "_hit"},   64'(h), 64'(v.hit));
        check({tag, "_lat"},   64'(l), 64'(v.lat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r, er;
        int h, l, eh, el;

        rst = 1'b1; i_req_valid = 0; i_paddr = '0; i_acc = '0; i_priv_m = 0;
        i_res_ready = 0; i_cfg_we = 0; i_addr_we = 0; i_wr_idx = '0; i_wr_data = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(o_res_valid), 64'd0);
        check("rst_route", 64'(o_route_2),   64'd0);
        check("rst_hit",   64'(o_hit_idx),   64'd0);
        check("rst_ready", 64'(o_req_ready), 64'd1);
        check("rst_busy",  64'(o_cfg_busy),  64'd0);
        rst = 1'b0;

        // Directed vectors: {paddr, acc, priv, route, hit, latency}
        vecs[0]  = '{34'h1000, 2'd0, 1'b0, 2'b01, 0, 1};
        vecs[1]  = '{34'h1000, 2'd1, 1'b0, 2'b10, 0, 1};
        vecs[2]  = '{34'h1000, 2'd1, 1'b1, 2'b01, 0, 1};
        vecs[3]  = '{34'h1000, 2'd2, 1'b0, 2'b10, 0, 1};
        vecs[4]  = '{34'h1000, 2'd3, 1'b1, 2'b10, 0, 1};
        vecs[5]  = '{34'h1000, 2'd1, 1'b1, 2'b10, 0, 1};  // after L=1
        vecs[6]  = '{34'h07FC, 2'd0, 1'b0, 2'b01, 3, 4};
        vecs[7]  = '{34'h0800, 2'd0, 1'b0, 2'b10, 0, 8};
        vecs[8]  = '{34'h0400, 2'd2, 1'b0, 2'b01, 3, 4};
        vecs[9]  = '{34'h03FC, 2'd0, 1'b0, 2'b10, 0, 8};
        vecs[10] = '{34'h0800, 2'd0, 1'b1, 2'b01, 0, 8};

        @(posedge clk); #1;
        idle_write(1'b0, 1'b1, 0, 32'h400);
        idle_write(1'b1, 1'b0, 0, 32'h11);       // NA4, R
        for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
        idle_write(1'b1, 1'b0, 0, 32'h91);       // lock entry 0
        run_vec("vec5", vecs[5]);
        idle_write(1'b0, 1'b1, 2, 32'h100);
        idle_write(1'b0, 1'b1, 3, 32'h200);
        idle_write(1'b1, 1'b0, 3, 32'h0F);       // TOR, RWX
        for (int i = 6; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Stall in RESP for 5 cycles; a cfg write issued meanwhile must be ignored
        i_req_valid = 1'b1; i_paddr = 34'h1000; i_acc = 2'd0; i_priv_m = 1'b0;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        @(posedge clk); #1;
        for (int j = 0; j < 5; j++) begin
            check($sformatf("hold%0d_valid", j), 64'(o_res_valid), 64'd1);
            check($sformatf("hold%0d_route", j), 64'(o_route_2),   64'd1);
            check($sformatf("hold%0d_ready", j), 64'(o_req_ready), 64'd0);
            check($sformatf("hold%0d_busy", j),  64'(o_cfg_busy),  64'd1);
            i_cfg_we  = (j == 1);
            i_wr_idx  = 3'd1;
            i_wr_data = 32'h11;
            @(posedge clk); #1;
            i_cfg_we  = 1'b0;
        end
        i_res_ready = 1'b1;
        @(posedge clk); #1;
        i_res_ready = 1'b0;
        run_vec("busy_wr", '{34'h0, 2'd0, 1'b0, 2'b10, 0, 8});

        // Reset while entry 2 is under evaluation
        i_req_valid = 1'b1; i_paddr = 34'h7FC; i_acc = 2'd0; i_priv_m = 1'b0;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(o_res_valid), 64'd0);
        check("midrst_ready", 64'(o_req_ready), 64'd1);
        check("midrst_route", 64'(o_route_2),   64'd0);
        @(posedge clk); #1;
        check("midrst_valid2", 64'(o_res_valid), 64'd0);
        rst = 1'b0;
        m_reset();
        run_vec("after_rst", '{34'h1000, 2'd0, 1'b0, 2'b10, 0, 8});

        // cfg write and request accept on the same edge: the scan sees the new cfg
        idle_write(1'b0, 1'b1, 1, 32'h10);
        do_req(34'h40, 2'd0, 1'b0, 1'b1, 1'b0, 1, 32'h11, r, h, l);
        check("simul_route", 64'(r), 64'b01);
        check("simul_hit",   64'(h), 64'd1);
        check("simul_lat",   64'(l), 64'd2);

        // NAPOT 4 KiB region at 0
        idle_write(1'b0, 1'b1, 0, 32'h1FF);
        idle_write(1'b1, 1'b0, 0, 32'h19);
`ifdef PMP_NAPOT_EN
        run_vec("napot_in", '{34'hFFC, 2'd0, 1'b0, 2'b01, 0, 1});
`else
        run_vec("napot_in", '{34'hFFC, 2'd0, 1'b0, 2'b10, 0, 8});
`endif
        run_vec("napot_out", '{34'h1000, 2'd0, 1'b0, 2'b10, 0, 8});

        // Locked TOR entry 5 freezes its own cfg and pmpaddr[4]
        pulse_reset();
        idle_write(1'b0, 1'b1, 4, 32'h20);
        idle_write(1'b0, 1'b1, 5, 32'h30);
        idle_write(1'b1, 1'b0, 5, 32'h89);
        idle_write(1'b0, 1'b1, 4, 32'h2C);
        idle_write(1'b1, 1'b0, 5, 32'h00);
        run_vec("lock_tor", '{34'h88, 2'd0, 1'b0, 2'b01, 5, 6});

        // Randomized traffic against the reference model
        pulse_reset();
        for (int it = 0; it < 300; it++) begin
            if (it % 50 == 49) pulse_reset();
            if ($urandom_range(0, 2) == 0) begin
                int widx = $urandom_range(0, N_ENT - 1);
                bit cwe  = $urandom_range(0, 1);
                logic [31:0] d;
                if (cwe) d = {24'd0, ($urandom_range(0, 7) == 0), 2'b00,
                              2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
                else d = $urandom_range(0, 127);
                idle_write(cwe, !cwe, widx, d);
            end else begin
                logic [33:0] pa   = 34'($urandom_range(0, 511));
                logic [1:0]  acc  = 2'($urandom_range(0, 3));
                bit          priv = $urandom_range(0, 1);
                bit          wr   = ($urandom_range(0, 3) == 0);
                bit          cwe  = $urandom_range(0, 1);
                int          widx = $urandom_range(0, N_ENT - 1);
                logic [31:0] d    = cwe ? 32'($urandom_range(0, 127) | 8'h08)
                                        : 32'($urandom_range(0, 127));
                do_req(pa, acc, priv, wr && cwe, wr && !cwe, widx, d, r, h, l);
                m_eval(pa, acc, priv, er, eh, el);
                check($sformatf("rnd%0d_route", it), 64'(r), 64'(er));
                check($sformatf("rnd%0d_hit", it),   64'(h), 64'(eh));
                check($sformatf("rnd%0d_lat", it),   64'(l), 64'(el));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pmp_check_seq.md
Name: pmp_check_seq

Overview:
- Clocked PMP checker, directly upstream of the two-way PMP route selector.
- Accepts one physical-address access request at a time and scans the PMP entries sequentially, one entry per cycle, stopping at the first match.
- Produces a registered one-hot 2-bit route vector (grant / fault) that is consumed as the selector's per-branch valid field.
- Holds its own PMP cfg/addr register file, written through a simple config port.

Parameters:
- PA_W, 34: physical address width in bits.
- N_ENT, 8: number of PMP entries; power of two, 2..16.
- IDX_W, $clog2(N_ENT): width of the entry index.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request ready; high only in IDLE
- i_paddr  in  PA_W  access physical address
- i_acc  in  2  access type: 00 read, 01 write, 10 execute, 11 reserved (treated as fault)
- i_priv_m  in  1  access is M-mode
- o_res_valid  out  1  result valid
- i_res_ready  in  1  result consumed
- o_route_2  out  2  one-hot route: [0] grant, [1] fault
- o_hit_idx  out  IDX_W  index of the matching entry; 0 if no match
- i_cfg_we  in  1  cfg byte write strobe
- i_addr_we  in  1  pmpaddr write strobe
- i_wr_idx  in  IDX_W  target entry
- i_wr_data  in  PA_W-2  write data; cfg uses [7:0] = {L,00,A[1:0],X,W,R}
- o_cfg_busy  out  1  high outside IDLE; writes are ignored while high

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all cfg=0 (A=OFF, L=0); all pmpaddr=0.
  - o_res_valid=0, o_route_2=00, o_hit_idx=0, o_req_ready=1, o_cfg_busy=0.
- FSM IDLE -> SCAN -> RESP -> IDLE.
- IDLE:
  - On i_req_valid & o_req_ready, latch paddr/acc/priv, set idx=0, go to SCAN.
  - Config writes are applied in IDLE only.
  - A write to a locked entry (L=1) is dropped.
  - A pmpaddr write to entry i is also dropped when entry i+1 is TOR and locked.
- SCAN: evaluate entry idx each cycle.
  - A=OFF: no match.
  - A=TOR: pmpaddr[idx-1] <= paddr[PA_W-1:2] < pmpaddr[idx]; lower bound is 0 for idx=0. An empty range (lower bound >= upper bound) never matches.
  - A=NA4: paddr[PA_W-1:2] == pmpaddr[idx].
  - A=NAPOT: see Optional Feature.
  - On match:
    - grant if (i_priv_m & !L) or the permission bit for acc is set; otherwise fault.
    - reserved acc always faults.
    - o_hit_idx=idx; go to RESP.
  - If idx==N_ENT-1 with no match: grant if priv_m, else fault; o_hit_idx=0; go to RESP.
- Latency:
  - A match at entry k gives o_res_valid=1 exactly k+1 edges after the accepting edge.
  - No match gives o_res_valid=1 after N_ENT edges.
- RESP:
  - o_res_valid=1 and o_route_2 are held stable until i_res_ready is sampled high; then go to IDLE and drop valid.
  - o_route_2 is 00 whenever o_res_valid=0.
  - o_route_2 is never 11.
- Simultaneous write strobe and request accept in IDLE: the write commits and the request is latched. The scan sees the new value on the next cycle (write precedes scan).
- Reset mid-SCAN or mid-RESP: the in-flight request is discarded, no result is emitted, and the config returns to its reset value.
- Back-to-back requests: ready returns one cycle after the RESP handshake. There is no bypass.

Optional Feature:
- Macro: PMP_NAPOT_EN.
- Defined:
  - A=NAPOT is decoded. Let t = number of trailing ones of pmpaddr.
  - Match iff paddr[PA_W-1:t+3] == pmpaddr[PA_W-3:t+1]; the region size is 2^(t+3) bytes.
  - All-ones pmpaddr matches every address.
- Undefined:
  - A=NAPOT is treated as OFF (never matches).
  - The trailing-ones logic is absent.

Decomposition:
- Package pmp_pkg:
  - A-field encodings OFF/TOR/NA4/NAPOT.
  - Access codes ACC_R/W/X.
  - Route bit positions ROUTE_GRANT=0, ROUTE_FAULT=1.
  - FSM state enum.
  - cfg bit positions (L=7, A=4:3, X=2, W=1, R=0).
- Sub-module pmp_entry_match:
  - Combinational match and permission evaluation for one entry.
  - Inputs: cfg, addr, prev addr, paddr, acc, priv.
  - Outputs: match, allow.

Test Plan:
- Entry 0 NA4, pmpaddr=0x400, cfg R=1; S-mode read paddr=0x1000 -> o_route_2=01, hit_idx=0, valid 1 edge after accept.
- Same entry, S-mode write 0x1000 -> route 10. M-mode write with L=0 -> 01. Set L=1, M-mode write -> 10.
- Entry 3 TOR, pmpaddr[2]=0x100, pmpaddr[3]=0x200, cfg RWX; read 0x7FC -> 01, idx=3, latency 4 edges; read 0x800 -> no match, S-mode -> 10 after 8 edges.
- Hold i_res_ready=0 for 5 cycles in RESP -> route and valid stable, ready=0; cfg write issued meanwhile has no effect (read back via a later access).
- Assert rst during SCAN of entry 2 -> next cycle valid=0, ready=1; a prior NA4 grant entry now gives S-mode fault 10.
- With PMP_NAPOT_EN: pmpaddr=0x1FF (t=9, 4 KiB region at 0), cfg R; read 0xFFC -> 01, read 0x1000 -> 10. Without the macro the same accesses both give 10.
